// File: rtl/proyecto_pc_core.sv
// proyecto_pc_core: single-cycle 8-bit processor running a fixed program from an internal ROM.
// Datapath: 4 x 8-bit register file, ALU with Z/C flags, 16-byte data RAM and an output latch.
// ROM_IMAGE packs word i at bits [16*i +: 16]. Its default is the built-in demo program.
module proyecto_pc_core #(
   parameter int unsigned PC_W    = 5,
   parameter int unsigned DMEM_AW = 4,
   parameter logic [16*(2**PC_W)-1:0] ROM_IMAGE = {
      {23{16'h0000}},
      16'hF000,  // 8 HLT
      16'hE800,  // 7 OUT R2
      16'h9802,  // 6 LD  R2,[2]
      16'hA002,  // 5 ST  R0,[2]
      16'h3100,  // 4 SUB R0,R1
      16'hE000,  // 3 OUT R0
      16'h2100,  // 2 ADD R0,R1
      16'h1403,  // 1 LDI R1,3
      16'h1005   // 0 LDI R0,5
   }
) (
   input  logic            clk,
   input  logic            rst,
   output logic [PC_W-1:0] pc,
   output logic [7:0]      out_port,
   output logic            out_valid,
   output logic            halted,
   output logic            zero_flag,
   output logic            carry_flag
);

   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_LDI = 4'h1;
   localparam logic [3:0] OP_ADD = 4'h2;
   localparam logic [3:0] OP_SUB = 4'h3;
   localparam logic [3:0] OP_AND = 4'h4;
   localparam logic [3:0] OP_OR  = 4'h5;
   localparam logic [3:0] OP_XOR = 4'h6;
   localparam logic [3:0] OP_SHL = 4'h7;
   localparam logic [3:0] OP_SHR = 4'h8;
   localparam logic [3:0] OP_LD  = 4'h9;
   localparam logic [3:0] OP_ST  = 4'hA;
   localparam logic [3:0] OP_JMP = 4'hB;
   localparam logic [3:0] OP_JZ  = 4'hC;
   localparam logic [3:0] OP_JC  = 4'hD;
   localparam logic [3:0] OP_OUT = 4'hE;
   localparam logic [3:0] OP_HLT = 4'hF;

   // Architectural state
   logic [PC_W-1:0] r_pc;
   logic [7:0]      r_regs [4];
   logic            r_z;
   logic            r_c;
   logic [7:0]      r_out;
   logic            r_out_valid;
   logic            r_halted;
   logic [7:0]      r_dmem [2**DMEM_AW];

   // Decode and datapath wires
   logic [15:0]        w_rom [2**PC_W];
   logic [15:0]        w_instr;
   logic [3:0]         w_op;
   logic [1:0]         w_rd;
   logic [1:0]         w_rs;
   logic [7:0]         w_imm;
   logic [7:0]         w_a;
   logic [7:0]         w_b;
   logic [DMEM_AW-1:0] w_dmem_addr;
   logic [7:0]         w_ld_data;
   logic [7:0]         w_alu_res;
   logic               w_alu_c;
   logic               w_alu_en;
   logic               w_rf_we;
   logic [7:0]         w_rf_wdata;
   logic [PC_W-1:0]    w_pc_inc;
   logic [PC_W-1:0]    w_jmp_tgt;
   logic [PC_W-1:0]    w_pc_next;

   for (genvar gi = 0; gi < 2**PC_W; gi++) begin : g_rom
      assign w_rom[gi] = ROM_IMAGE[16*gi +: 16];
   end

   assign w_instr     = w_rom[r_pc];
   assign w_op        = w_instr[15:12];
   assign w_rd        = w_instr[11:10];
   assign w_rs        = w_instr[9:8];
   assign w_imm       = w_instr[7:0];
   assign w_a         = r_regs[w_rd];
   assign w_b         = r_regs[w_rs];
   assign w_dmem_addr = w_imm[DMEM_AW-1:0];
   assign w_ld_data   = r_dmem[w_dmem_addr];
   assign w_pc_inc    = r_pc + PC_W'(1);
   assign w_jmp_tgt   = w_imm[PC_W-1:0];

   // ALU: result and carry/borrow for opcodes 2-8; w_alu_en marks flag-updating ops
   always_comb begin
      w_alu_res = 8'h00;
      w_alu_c   = 1'b0;
      w_alu_en  = 1'b1;
      case (w_op)
         OP_ADD: {w_alu_c, w_alu_res} = {1'b0, w_a} + {1'b0, w_b};
         OP_SUB: begin
            w_alu_res = w_a - w_b;
            w_alu_c   = (w_a < w_b);
         end
         OP_AND: w_alu_res = w_a & w_b;
         OP_OR:  w_alu_res = w_a | w_b;
         OP_XOR: w_alu_res = w_a ^ w_b;
         OP_SHL: begin
            w_alu_res = {w_a[6:0], 1'b0};
            w_alu_c   = w_a[7];
         end
         OP_SHR: begin
            w_alu_res = {1'b0, w_a[7:1]};
            w_alu_c   = w_a[0];
         end
         default: w_alu_en = 1'b0;
      endcase
   end

   // Register-file write source selection
   always_comb begin
      w_rf_we    = w_alu_en;
      w_rf_wdata = w_alu_res;
      case (w_op)
         OP_LDI: begin
            w_rf_we    = 1'b1;
            w_rf_wdata = w_imm;
         end
         OP_LD: begin
            w_rf_we    = 1'b1;
            w_rf_wdata = w_ld_data;
         end
         default: ;
      endcase
   end

   // Next PC: branches test the flags held before this instruction
   always_comb begin
      w_pc_next = w_pc_inc;
      case (w_op)
         OP_JMP: w_pc_next = w_jmp_tgt;
         OP_JZ:  if (r_z) w_pc_next = w_jmp_tgt;
         OP_JC:  if (r_c) w_pc_next = w_jmp_tgt;
         OP_HLT: w_pc_next = r_pc;
         default: ;
      endcase
   end

   // Core state update; everything freezes once halted
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc        <= '0;
         for (int i = 0; i < 4; i++) r_regs[i] <= 8'h00;
         r_z         <= 1'b0;
         r_c         <= 1'b0;
         r_out       <= 8'h00;
         r_out_valid <= 1'b0;
         r_halted    <= 1'b0;
      end else begin
         r_out_valid <= 1'b0;
         if (!r_halted) begin
            r_pc <= w_pc_next;
            if (w_rf_we) r_regs[w_rd] <= w_rf_wdata;
            if (w_alu_en) begin
               r_z <= (w_alu_res == 8'h00);
               r_c <= w_alu_c;
            end
            if (w_op == OP_OUT) begin
               r_out       <= w_a;
               r_out_valid <= 1'b1;
            end
            if (w_op == OP_HLT) r_halted <= 1'b1;
         end
      end
   end

   // Data RAM: not reset, writes suppressed while in reset or halted
   always_ff @(posedge clk) begin
      if (!rst && !r_halted && (w_op == OP_ST)) r_dmem[w_dmem_addr] <= w_a;
   end

   assign pc         = r_pc;
   assign out_port   = r_out;
   assign out_valid  = r_out_valid;
   assign halted     = r_halted;
   assign zero_flag  = r_z;
   assign carry_flag = r_c;

endmodule

// File: tb/tb_proyecto_pc_core.sv
// Bench for proyecto_pc_core: runs the default program and a second ROM image side by side,
// comparing every cycle against an instruction-level model of the processor.
module tb_proyecto_pc_core;

   localparam logic [511:0] DEF_ROM = {
      {23{16'h0000}},
      16'hF000, 16'hE800, 16'h9802, 16'hA002, 16'h3100, 16'hE000, 16'h2100, 16'h1403, 16'h1005
   };

   // Arithmetic, branch, shift and wrap-around program; loops forever via JMP 31 / NOP
   localparam logic [511:0] TEST_ROM = {
      16'h0000, 16'hB01F, 16'hF000, 16'hD01E,   // 31 NOP, 30 JMP 31, 29 HLT, 28 JC 30
      16'h3D00, 16'hD01E, 16'hE000, 16'h4100,   // 27 SUB R3,R1, 26 JC 30, 25 OUT R0, 24 AND R0,R1
      16'h5300, 16'h6200, 16'h9003, 16'hA413,   // 23 OR R0,R3, 22 XOR R0,R2, 21 LD R0,[3], 20 ST R1,[0x13]
      16'hE400, 16'h2500, 16'h143C, 16'hEC00,   // 19 OUT R1, 18 ADD R1,R1, 17 LDI R1,0x3C, 16 OUT R3
      16'h8C00, 16'h1C01, 16'hE800, 16'h7800,   // 15 SHR R3, 14 LDI R3,1, 13 OUT R2, 12 SHL R2
      16'h1881, 16'hD000, 16'h0000, 16'h0000,   // 11 LDI R2,0x81, 10 JC 0, 9 NOP, 8 NOP
      16'hF000, 16'hC00A, 16'hE000, 16'h3000,   // 7 HLT, 6 JZ 10, 5 OUT R0, 4 SUB R0,R0
      16'hE000, 16'h2100, 16'h1464, 16'h10C8    // 3 OUT R0, 2 ADD R0,R1, 1 LDI R1,100, 0 LDI R0,200
   };

   logic       clk;
   logic       rst;
   logic [4:0] pc_d, pc_t;
   logic [7:0] out_d, out_t;
   logic       ov_d, ov_t, h_d, h_t, z_d, z_t, c_d, c_t;

   int n_pass  = 0;
   int n_fail  = 0;
   int n_total = 0;

   // Reference model state, index 0 = default program, 1 = test program
   int m_pc   [2];
   int m_reg  [2][4];
   int m_ram  [2][16];
   int m_z    [2];
   int m_c    [2];
   int m_out  [2];
   int m_ov   [2];
   int m_halt [2];

   proyecto_pc_core u_dut_def (
      .clk        (clk),
      .rst        (rst),
      .pc         (pc_d),
      .out_port   (out_d),
      .out_valid  (ov_d),
      .halted     (h_d),
      .zero_flag  (z_d),
      .carry_flag (c_d)
   );

   proyecto_pc_core #(
      .ROM_IMAGE (TEST_ROM)
   ) u_dut_tst (
      .clk        (clk),
      .rst        (rst),
      .pc         (pc_t),
      .out_port   (out_t),
      .out_valid  (ov_t),
      .halted     (h_t),
      .zero_flag  (z_t),
      .carry_flag (c_t)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int rom_word(input int d, input int addr);
      logic [511:0] img;
      img = (d == 0) ? DEF_ROM : TEST_ROM;
      return int'(img[16*addr +: 16]);
   endfunction

   task automatic model_reset(input int d);
      m_pc[d] = 0;
      for (int i = 0; i < 4; i++) m_reg[d][i] = 0;
      m_z[d] = 0; m_c[d] = 0; m_out[d] = 0; m_ov[d] = 0; m_halt[d] = 0;
   endtask

   // One instruction, computed from the ISA description with plain integer arithmetic
   task automatic model_step(input int d);
      int w, op, rd, rs, imm, a, b, res, nxt, s;
      bit alu;
      m_ov[d] = 0;
      if (m_halt[d] != 0) return;
      w   = rom_word(d, m_pc[d]);
      op  = w / 4096;
      rd  = (w / 1024) % 4;
      rs  = (w / 256) % 4;
      imm = w % 256;
      a   = m_reg[d][rd];
      b   = m_reg[d][rs];
      nxt = (m_pc[d] + 1) % 32;
      alu = 1'b1;
      res = 0;
      case (op)
         2: begin s = a + b; res = s % 256; m_c[d] = (s > 255); end
         3: begin res = (a - b + 256) % 256; m_c[d] = (a < b); end
         4: begin res = a & b; m_c[d] = 0; end
         5: begin res = a | b; m_c[d] = 0; end
         6: begin res = a ^ b; m_c[d] = 0; end
         7: begin res = (a * 2) % 256; m_c[d] = (a >= 128); end
         8: begin res = a / 2; m_c[d] = a % 2; end
         default: alu = 1'b0;
      endcase
      case (op)
         1:  m_reg[d][rd] = imm;
         9:  m_reg[d][rd] = m_ram[d][imm % 16];
         10: m_ram[d][imm % 16] = a;
         11: nxt = imm % 32;
         12: if (m_z[d] != 0) nxt = imm % 32;
         13: if (m_c[d] != 0) nxt = imm % 32;
         14: begin m_out[d] = a; m_ov[d] = 1; end
         15: begin m_halt[d] = 1; nxt = m_pc[d]; end
         default: ;
      endcase
      if (alu) begin
         m_reg[d][rd] = res;
         m_z[d] = (res == 0);
      end
      m_pc[d] = nxt;
   endtask

   task automatic compare_all();
      chk("def_pc",   32'(pc_d),  m_pc[0]);
      chk("def_out",  32'(out_d), m_out[0]);
      chk("def_ov",   32'(ov_d),  m_ov[0]);
      chk("def_halt", 32'(h_d),   m_halt[0]);
      chk("def_z",    32'(z_d),   m_z[0]);
      chk("def_c",    32'(c_d),   m_c[0]);
      chk("tst_pc",   32'(pc_t),  m_pc[1]);
      chk("tst_out",  32'(out_t), m_out[1]);
      chk("tst_ov",   32'(ov_t),  m_ov[1]);
      chk("tst_halt", 32'(h_t),   m_halt[1]);
      chk("tst_z",    32'(z_t),   m_z[1]);
      chk("tst_c",    32'(c_t),   m_c[1]);
   endtask

   // Advance n clock edges; outputs sampled on the falling edge
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         if (!rst) begin
            model_step(0);
            model_step(1);
         end
         @(negedge clk);
         compare_all();
      end
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < 16; i++) m_ram[d][i] = 0;
         model_reset(d);
      end
      rst = 1'b1;
      @(negedge clk);
      tick(2);
      chk("rst_pc",   32'(pc_d),  0);
      chk("rst_out",  32'(out_d), 0);
      chk("rst_halt", 32'(h_d),   0);
      chk("rst_zc",   32'({z_d, c_d}), 0);
      rst = 1'b0;

      tick(3);  // edge 3: ADD 200+100
      chk("add_c", 32'(c_t), 1);
      chk("add_z", 32'(z_t), 0);
      chk("def_no_out", 32'(ov_d), 0);
      tick(1);  // edge 4
      chk("def_out1", 32'(out_d), 8);
      chk("def_ov1",  32'(ov_d),  1);
      chk("add_res",  32'(out_t), 44);
      tick(1);  // edge 5: SUB R0,R0
      chk("def_ov_pulse", 32'(ov_d), 0);
      chk("sub_z", 32'(z_t), 1);
      chk("sub_c", 32'(c_t), 0);
      tick(2);  // edge 7: JZ 10 taken
      chk("jz_pc", 32'(pc_t), 10);
      tick(1);  // edge 8: JC 0 not taken
      chk("def_out2", 32'(out_d), 5);
      chk("def_ov2",  32'(ov_d),  1);
      chk("jc_pc",    32'(pc_t),  11);
      tick(1);  // edge 9: HLT
      chk("def_halt", 32'(h_d),  1);
      chk("def_hpc",  32'(pc_d), 8);
      tick(1);  // edge 10: SHL 0x81
      chk("def_hpc2", 32'(pc_d), 8);
      chk("def_hov",  32'(ov_d), 0);
      chk("shl_c", 32'(c_t), 1);
      chk("shl_z", 32'(z_t), 0);
      tick(1);
      chk("shl_res", 32'(out_t), 2);
      tick(2);  // edge 13: SHR 0x01
      chk("shr_z", 32'(z_t), 1);
      chk("shr_c", 32'(c_t), 1);
      tick(4);
      chk("add_self", 32'(out_t), 8'h78);
      tick(6);
      chk("logic_res", 32'(out_t), 8'h78);
      tick(2);  // edge 25: SUB borrow
      chk("borrow_c", 32'(c_t), 1);
      chk("borrow_z", 32'(z_t), 0);
      tick(1);
      chk("jc_taken", 32'(pc_t), 30);
      tick(1);
      chk("jmp31", 32'(pc_t), 31);
      tick(1);
      chk("wrap_pc", 32'(pc_t), 0);
      chk("def_still_halted", 32'(pc_d), 8);

      // Random run lengths with asynchronous resets landing between clock edges
      for (int it = 0; it < 8; it++) begin
         tick(int'($urandom_range(5, 45)));
         #2;
         rst = 1'b1;
         #1;
         chk("async_pc_def", 32'(pc_d), 0);
         chk("async_pc_tst", 32'(pc_t), 0);
         chk("async_out",    32'(out_t), 0);
         chk("async_halt",   32'(h_d),  0);
         model_reset(0);
         model_reset(1);
         @(negedge clk);
         tick(int'($urandom_range(0, 2)));
         rst = 1'b0;
      end
      tick(12);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/proyecto_pc_core.md
Name: proyecto_pc_core

Overview:
- Minimal single-cycle 8-bit processor ("personal computer" project top) that executes a fixed program from an internal instruction ROM.
- Contains an 8-bit datapath, a 4-register file, an ALU with Z/C flags, a 16-byte data RAM and an output latch.
- Only clk and rst are required to run it. All other ports are observation outputs and may be left unconnected.

Parameters:
- PC_W, 5, program counter width; ROM depth = 2**PC_W = 32 words of 16 bits.
- DMEM_AW, 4, data RAM address width; 16 bytes.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- pc  out  PC_W  current program counter.
- out_port  out  8  value latched by the last OUT instruction.
- out_valid  out  1  one-cycle pulse in the cycle after an OUT executes.
- halted  out  1  high once HLT has executed.
- zero_flag  out  1  Z flag.
- carry_flag  out  1  C flag.

Behaviour:
- Reset (asynchronous, active-high) clears the following to 0: pc, R0-R3, Z, C, out_port, out_valid and halted. Data RAM contents are not reset.
- Instruction format, 16 bits: op[15:12], rd[11:10], rs[9:8], imm[7:0].
- Single-cycle operation: each rising edge while not halted executes ROM[pc].
- pc defaults to pc+1 and wraps from 31 to 0.
- Opcode map:
  - 0 NOP.
  - 1 LDI: rd=imm.
  - 2 ADD: rd=rd+rs, C=carry-out.
  - 3 SUB: rd=rd-rs, C=borrow (rd<rs unsigned).
  - 4 AND, 5 OR, 6 XOR: rd=rd op rs, C=0.
  - 7 SHL: rd=rd<<1, C=old bit7.
  - 8 SHR: rd=rd>>1 logical, C=old bit0.
  - 9 LD: rd=RAM[imm[3:0]].
  - A ST: RAM[imm[3:0]]=rd.
  - B JMP: pc=imm[4:0].
  - C JZ: if Z then pc=imm[4:0].
  - D JC: if C then pc=imm[4:0].
  - E OUT: out_port=rd, out_valid=1 for the next cycle.
  - F HLT: halted=1 and pc holds.
- Flag updates:
  - Z=(result==0) for opcodes 2-8 only.
  - C is updated only by opcodes 2-8.
  - All other opcodes leave both flags unchanged.
- Arithmetic is modulo 256. The RAM address uses only imm[3:0].
- When rd==rs the operation uses the pre-edge value of rd (e.g. ADD R0,R0 doubles R0).
- JZ and JC test the flags as they were before the current instruction.
- While halted: no state changes and out_valid=0. Only reset restarts execution.
- Reset mid-program returns pc to 0 immediately, without waiting for a clock edge.
- Default ROM program; unused locations are NOP:
  - 0 LDI R0,5
  - 1 LDI R1,3
  - 2 ADD R0,R1
  - 3 OUT R0
  - 4 SUB R0,R1
  - 5 ST R0,[2]
  - 6 LD R2,[2]
  - 7 OUT R2
  - 8 HLT
- Timing of the default program after reset release:
  - The OUT at address 3 is executed on the 4th rising edge; out_port=8 from then on.
  - The OUT at address 7 is executed on the 8th edge; out_port=5.
  - halted=1 after the 9th edge, with pc=8.

Test Plan:
- Assert rst with clk running, then release it -> pc=0, out_port=0, halted=0, Z=C=0. Asserting rst again mid-run forces pc=0 without a clock edge.
- Default program, 10 clock edges after reset release:
  - out_valid pulses after edges 4 and 8, with out_port=8 then 5.
  - halted=1 and pc=8 from edge 9 onward.
  - Further edges change nothing.
- ROM image LDI R0,200; LDI R1,100; ADD R0,R1 -> R0=44, C=1, Z=0. Follow with SUB R0,R0 -> R0=0, Z=1, C=0.
- Branch check with Z=1 from the previous scenario: JZ 10 -> pc=10. Then JC 0 with C=0 -> pc=11.
- SHL on 0x81 -> 0x02 with C=1. SHR on 0x01 -> 0x00 with Z=1 and C=1.
- JMP 31 followed by NOP at address 31 -> pc wraps to 0.
